// File: rtl/qpp_index_gen_par.sv
// Multi-lane QPP interleaver index generator.
// Streams Pi(i) = (f1*i + f2*i^2) mod K, LANES indices per beat.
`timescale 1ns/1ps
module qpp_index_gen_par #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_WIDTH-1:0]       f1_tdata,
    input  logic [DATA_WIDTH-1:0]       f2_tdata,
    input  logic [DATA_WIDTH-1:0]       k_tdata,
    input  logic                        k_tvalid,
    output logic                        k_tready,
    output logic                        ind_tvalid,
    input  logic                        ind_tready,
    output logic [LANES*DATA_WIDTH-1:0] ind_tdata,
    output logic [LANES-1:0]            ind_tkeep,
    output logic                        ind_tuser,
    output logic                        ind_tlast,
    output logic                        cfg_err
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(2*LANES+3);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_STREAM} state_t;

    function automatic logic [DW-1:0] add_mod(
        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[DW-1:0];
    endfunction

    // True result lies in [0,m), so DW-bit wraparound of a-b+m is exact.
    function automatic logic [DW-1:0] sub_mod(
        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m);
        if (a >= b)
            return a - b;
        return a - b + m;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            first_q, first_d;
    logic            cfg_err_q, cfg_err_d;
    logic [DW-1:0]   f1_q, f1_d, f2_q, f2_d, k_q, k_d;
    logic [DW-1:0]   p_q, p_d, g_q, g_d, c_q, c_d;
    logic [DW-1:0]   pl_q, pl_d, dd_q, dd_d;
    logic [DW-1:0]   lane_pi_q [LANES];
    logic [DW-1:0]   lane_pi_d [LANES];
    logic [DW-1:0]   lane_d_q  [LANES];
    logic [DW-1:0]   lane_d_d  [LANES];
    logic            last;
    logic            bad_cfg;
    logic            stream;
    logic [LANES-1:0] keep;

    assign stream  = (state_q == S_STREAM);
    assign last    = (rem_q <= DW'(LANES));
    assign bad_cfg = (k_tdata == '0) || (f1_tdata >= k_tdata) ||
                     (f2_tdata >= k_tdata);

    always_comb begin
        keep = '0;
        for (int j = 0; j < LANES; j++)
            keep[j] = (rem_q > DW'(j));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        first_d   = first_q;
        cfg_err_d = 1'b0;
        f1_d      = f1_q;
        f2_d      = f2_q;
        k_d       = k_q;
        p_d       = p_q;
        g_d       = g_q;
        c_d       = c_q;
        pl_d      = pl_q;
        dd_d      = dd_q;
        lane_pi_d = lane_pi_q;
        lane_d_d  = lane_d_q;
        unique case (state_q)
            S_IDLE: begin
                if (k_tvalid) begin
                    f1_d = f1_tdata;
                    f2_d = f2_tdata;
                    k_d  = k_tdata;
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = S_INIT;
                        cnt_d   = '0;
                        rem_d   = k_tdata;
                        first_d = 1'b1;
                    end
                end
            end
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                // Slot 0 seeds the recurrence; slots 1..2L+1 are steps 0..2L.
                if (cnt_q == '0) begin
                    p_d = '0;
                    g_d = add_mod(f1_q, f2_q, k_q);
                    c_d = add_mod(f2_q, f2_q, k_q);
                end else begin
                    p_d = add_mod(p_q, g_q, k_q);
                    g_d = add_mod(g_q, c_q, k_q);
                    for (int j = 0; j < LANES; j++) begin
                        if (cnt_q == CW'(j+1))
                            lane_pi_d[j] = p_q;
                        if (cnt_q == CW'(j+LANES+1))
                            lane_d_d[j] = sub_mod(p_q, lane_pi_q[j], k_q);
                    end
                    if (cnt_q == CW'(LANES+1))
                        pl_d = p_q;
                    if (cnt_q == CW'(2*LANES+1)) begin
                        dd_d    = sub_mod(sub_mod(p_q, pl_q, k_q),
                                          lane_d_q[0], k_q);
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (ind_tready) begin
                    for (int j = 0; j < LANES; j++) begin
                        lane_pi_d[j] = add_mod(lane_pi_q[j], lane_d_q[j], k_q);
                        lane_d_d[j]  = add_mod(lane_d_q[j], dd_q, k_q);
                    end
                    rem_d   = rem_q - DW'(LANES);
                    first_d = 1'b0;
                    if (last)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge aclk) begin
        f1_q      <= f1_d;
        f2_q      <= f2_d;
        k_q       <= k_d;
        p_q       <= p_d;
        g_q       <= g_d;
        c_q       <= c_d;
        pl_q      <= pl_d;
        dd_q      <= dd_d;
        lane_pi_q <= lane_pi_d;
        lane_d_q  <= lane_d_d;
    end

    assign k_tready   = (state_q == S_IDLE);
    assign cfg_err    = cfg_err_q;
    assign ind_tvalid = stream;
    assign ind_tuser  = stream & first_q;
    assign ind_tlast  = stream & last;
    assign ind_tkeep  = stream ? keep : '0;

    always_comb begin
        ind_tdata = '0;
        for (int j = 0; j < LANES; j++)
            if (ind_tkeep[j])
                ind_tdata[j*DW +: DW] = lane_pi_q[j];
    end

endmodule
